// File: rtl/fetch_decode_ctrl.sv
// Fetch/decode/sequencing controller for the RV32I R-type register-file + ALU datapath.
// Issues RR_En, F_En and Reg_Write as one-cycle Moore strobes in place of phase clocks.
module fetch_decode_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic [31:0] IM_Addr,
  output logic        IM_Req,
  input  logic        IM_Ready,
  input  logic [31:0] IM_Data,
  output logic [4:0]  R_Addr_A,
  output logic [4:0]  R_Addr_B,
  output logic [4:0]  W_Addr,
  output logic [3:0]  ALU_OP,
  output logic        RR_En,
  output logic        F_En,
  output logic        Reg_Write,
  output logic        Illegal,
  output logic [31:0] Retired
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StRr     = 3'd3;
  localparam logic [2:0] StEx     = 3'd4;
  localparam logic [2:0] StWb     = 3'd5;
  localparam logic [2:0] StHalt   = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] retired_q, retired_d;
  logic        illegal_q, illegal_d;
  logic        legal;

  // Only ADD..AND (funct7=0) plus SUB and SRA (funct7=0100000) are supported.
  always_comb begin
    legal = 1'b0;
    if (ir_q[6:0] == 7'b0110011) begin
      if (ir_q[31:25] == 7'b0000000) begin
        legal = 1'b1;
      end else if (ir_q[31:25] == 7'b0100000) begin
        legal = (ir_q[14:12] == 3'b000) || (ir_q[14:12] == 3'b101);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        if (IM_Ready) begin
          ir_d    = IM_Data;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (legal) begin
          state_d = StRr;
        end else begin
          state_d   = StHalt;
          illegal_d = 1'b1;
        end
      end
      StRr:   state_d = StEx;
      StEx:   state_d = StWb;
      StWb: begin
        pc_d      = pc_q + 32'd4;
        retired_d = retired_q + 32'd1;
        state_d   = run ? StFetch : StIdle;
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= PC_RESET;
      ir_q      <= 32'h0;
      retired_q <= 32'h0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  assign IM_Addr   = pc_q;
  assign IM_Req    = (state_q == StFetch);
  assign R_Addr_A  = ir_q[19:15];
  assign R_Addr_B  = ir_q[24:20];
  assign W_Addr    = ir_q[11:7];
  assign ALU_OP    = {ir_q[30], ir_q[14:12]};
  assign RR_En     = (state_q == StRr);
  assign F_En      = (state_q == StEx);
  assign Reg_Write = (state_q == StWb) && (ir_q[11:7] != 5'd0);
  assign Illegal   = illegal_q;
  assign Retired   = retired_q;

endmodule
